clkdiv_bank: RTL and testbench

CLKDIV_BANK -- requirements
Module: clkdiv_bank

---
 rtl/clkdiv_bank.sv | 112 +++++++++++
 tb/tb_clkdiv_bank.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/clkdiv_bank.sv
// Bank of independent programmable clock dividers with glitch-free, boundary-synchronised
// reprogramming through a per-channel shadow divisor/high-time pair.
module clkdiv_bank #(
  parameter int unsigned             CHANNELS        = 4,
  parameter int unsigned             WIDTH           = 28,
  parameter logic [WIDTH-1:0]        DEFAULT_DIVISOR = 28'd107296
) (
  input  logic                clock_in,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] enable,
  input  logic                load,
  input  logic [3:0]          load_ch,
  input  logic [WIDTH-1:0]    load_div,
  input  logic [WIDTH-1:0]    load_high,
  output logic [CHANNELS-1:0] clock_out,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] pending,
  output logic                load_err
);

  localparam logic [WIDTH-1:0] DEFAULT_HIGH = DEFAULT_DIVISOR >> 1;

  logic             accept;
  logic [WIDTH-1:0] high_new;

  always_comb begin
    accept = load && (32'(load_ch) < CHANNELS) && (load_div >= WIDTH'(2));
  end

  always_comb begin
    high_new = load_high;
    if (load_high == '0)
      high_new = WIDTH'(1);
    else if (load_high > load_div - WIDTH'(1))
      high_new = load_div - WIDTH'(1);
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) load_err <= 1'b0;
    else          load_err <= load && !accept;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] cnt, div_q, high_q, div_sh, high_sh;
    logic             run, co, tk, pend;
    logic             sel, live, wrap;

    always_comb begin
      sel  = accept && (load_ch == 4'(i));
      // run delays the first counting edge by one so a freshly enabled channel starts cleanly at cnt = 0
      live = enable[i] && run;
      wrap = (cnt == div_q - WIDTH'(1));
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
        cnt     <= '0;
        div_q   <= DEFAULT_DIVISOR;
        div_sh  <= DEFAULT_DIVISOR;
        high_q  <= DEFAULT_HIGH;
        high_sh <= DEFAULT_HIGH;
        pend    <= 1'b0;
        run     <= 1'b0;
        co      <= 1'b0;
        tk      <= 1'b0;
      end else begin
        run <= enable[i];
        if (!live) begin
          cnt <= '0;
          co  <= 1'b0;
          tk  <= 1'b0;
          if (sel) begin
            div_q   <= load_div;
            div_sh  <= load_div;
            high_q  <= high_new;
            high_sh <= high_new;
            pend    <= 1'b0;
          end else if (pend) begin
            div_q  <= div_sh;
            high_q <= high_sh;
            pend   <= 1'b0;
          end
        end else begin
          co <= (cnt < high_q);
          tk <= (cnt == '0);
          if (wrap) begin
            cnt <= '0;
            if (pend) begin
              div_q  <= div_sh;
              high_q <= high_sh;
            end
          end else begin
            cnt <= cnt + WIDTH'(1);
          end
          // a load on the boundary edge lands in the shadow after the old shadow was consumed
          if (sel) begin
            div_sh  <= load_div;
            high_sh <= high_new;
            pend    <= 1'b1;
          end else if (wrap) begin
            pend <= 1'b0;
          end
        end
      end
    end

    assign clock_out[i] = co;
    assign tick[i]      = tk;
    assign pending[i]   = pend;
  end

endmodule

// File: tb/tb_clkdiv_bank.sv
// Scoreboard bench for clkdiv_bank: a cycle model pushes expected outputs each cycle, popped after the edge.
module tb_clkdiv_bank;

  localparam int unsigned CH = 2;
  localparam int unsigned W  = 8;
  localparam logic [7:0]  DEF = 8'd10;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [CH-1:0] en;
  logic          ld;
  logic [3:0]    ld_ch;
  logic [W-1:0]  ld_div, ld_high;
  logic [CH-1:0] clock_out, tick, pending;
  logic          load_err;

  clkdiv_bank #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_DIVISOR(DEF)) dut (
    .clock_in(clk), .reset_n(reset_n), .enable(en), .load(ld), .load_ch(ld_ch),
    .load_div(ld_div), .load_high(ld_high), .clock_out(clock_out), .tick(tick),
    .pending(pending), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [7:0]    m_cnt[CH], m_d[CH], m_h[CH], m_ds[CH], m_hs[CH];
  logic [CH-1:0] m_pend, m_run, m_co, m_tk;
  logic          m_err;
  logic [6:0]    sb_q[$];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_cnt[i] = 8'd0; m_d[i] = DEF; m_ds[i] = DEF;
      m_h[i] = DEF / 2; m_hs[i] = DEF / 2;
    end
    m_pend = '0; m_run = '0; m_co = '0; m_tk = '0; m_err = 1'b0;
  endtask

  task automatic model_step();
    logic       acc, sel, wrap;
    logic [7:0] hnew;
    acc  = ld && (ld_ch < 4'd2) && (ld_div >= 8'd2);
    hnew = (ld_high == 8'd0) ? 8'd1 : ((ld_high >= ld_div) ? ld_div - 8'd1 : ld_high);
    m_err = ld && !acc;
    for (int i = 0; i < CH; i++) begin
      sel = acc && (ld_ch == 4'(i));
      if (!(en[i] && m_run[i])) begin
        m_cnt[i] = 8'd0; m_co[i] = 1'b0; m_tk[i] = 1'b0;
        if (sel) begin
          m_d[i] = ld_div; m_ds[i] = ld_div; m_h[i] = hnew; m_hs[i] = hnew; m_pend[i] = 1'b0;
        end else if (m_pend[i]) begin
          m_d[i] = m_ds[i]; m_h[i] = m_hs[i]; m_pend[i] = 1'b0;
        end
      end else begin
        m_co[i] = m_cnt[i] < m_h[i];
        m_tk[i] = m_cnt[i] == 8'd0;
        wrap = m_cnt[i] == m_d[i] - 8'd1;
        if (wrap) begin
          m_cnt[i] = 8'd0;
          if (m_pend[i]) begin m_d[i] = m_ds[i]; m_h[i] = m_hs[i]; end
        end else begin
          m_cnt[i] = m_cnt[i] + 8'd1;
        end
        if (sel) begin
          m_ds[i] = ld_div; m_hs[i] = hnew; m_pend[i] = 1'b1;
        end else if (wrap) begin
          m_pend[i] = 1'b0;
        end
      end
      m_run[i] = en[i];
    end
  endtask

  // One clock: model predicts, DUT advances, oldest prediction is compared #1 after the edge.
  task automatic cycle();
    logic [6:0] e;
    if (!reset_n) model_reset();
    else          model_step();
    sb_q.push_back({m_co, m_tk, m_pend, m_err});
    @(posedge clk); #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check("clock_out", 32'(clock_out), 32'(e[6:5]));
      check("tick",      32'(tick),      32'(e[4:3]));
      check("pending",   32'(pending),   32'(e[2:1]));
      check("load_err",  32'(load_err),  32'(e[0]));
    end
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic run_until(input int ch, input logic [7:0] val);
    int k;
    k = 0;
    while (m_cnt[ch] != val && k < 40) begin cycle(); k++; end
    if (m_cnt[ch] != val) check("run_until_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_load(input logic [3:0] c, input logic [7:0] d, input logic [7:0] h);
    ld = 1'b1; ld_ch = c; ld_div = d; ld_high = h;
    cycle();
    ld = 1'b0;
  endtask

  // Independent of the model: over any window of one period, count high cycles and ticks.
  task automatic measure(input int ch, input int period, input int exp_high, input int exp_ticks);
    int hi, tk;
    hi = 0; tk = 0;
    for (int k = 0; k < period; k++) begin
      cycle();
      hi += int'(clock_out[ch]);
      tk += int'(tick[ch]);
    end
    check($sformatf("high_cnt_ch%0d_p%0d", ch, period), 32'(hi), 32'(exp_high));
    check($sformatf("tick_cnt_ch%0d_p%0d", ch, period), 32'(tk), 32'(exp_ticks));
  endtask

  initial begin
    reset_n = 1'b0; en = '0; ld = 1'b0; ld_ch = '0; ld_div = '0; ld_high = '0;
    model_reset();
    #1;
    check("rst_clock_out", 32'(clock_out), 32'd0);
    check("rst_tick",      32'(tick),      32'd0);
    check("rst_pending",   32'(pending),   32'd0);
    check("rst_load_err",  32'(load_err),  32'd0);
    cycles(2);
    reset_n = 1'b1;

    en = 2'b11;
    cycles(12);
    measure(0, 10, 5, 1);
    measure(1, 10, 5, 1);

    run_until(0, 8'd3);
    do_load(4'd0, 8'd4, 8'd1);
    check("pend_after_load", 32'(pending[0]), 32'd1);
    cycles(12);
    measure(0, 4, 1, 1);
    measure(1, 10, 5, 1);

    do_load(4'd0, 8'd1, 8'd1);
    check("err_div1", 32'(load_err), 32'd1);
    do_load(4'd3, 8'd5, 8'd2);
    check("err_ch3", 32'(load_err), 32'd1);
    cycle();
    check("err_clear", 32'(load_err), 32'd0);
    check("err_no_pend", 32'(pending), 32'd0);

    do_load(4'd1, 8'd6, 8'd9);
    cycles(14);
    measure(1, 6, 5, 1);
    do_load(4'd1, 8'd6, 8'd0);
    cycles(14);
    measure(1, 6, 1, 1);

    run_until(0, 8'd0);
    do_load(4'd0, 8'd4, 8'd3);
    do_load(4'd0, 8'd8, 8'd2);
    cycles(12);
    measure(0, 8, 2, 1);

    run_until(0, 8'd7);
    do_load(4'd0, 8'd5, 8'd3);
    check("pend_boundary_load", 32'(pending[0]), 32'd1);
    cycles(14);
    measure(0, 5, 3, 1);

    en = 2'b01;
    cycle();
    do_load(4'd1, 8'd5, 8'd2);
    check("disabled_no_pend", 32'(pending[1]), 32'd0);
    en = 2'b11;
    cycle();
    check("enable_first_edge", 32'(clock_out[1]), 32'd0);
    cycle();
    check("enable_second_edge", 32'(tick[1]), 32'd1);
    measure(1, 5, 2, 1);

    run_until(0, 8'd1);
    do_load(4'd0, 8'd4, 8'd2);
    check("pend_before_reset", 32'(pending[0]), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_clock_out", 32'(clock_out), 32'd0);
    check("midrst_pending",   32'(pending),   32'd0);
    check("midrst_tick",      32'(tick),      32'd0);
    sb_q.delete();
    model_reset();
    @(posedge clk); #1;
    cycles(2);
    reset_n = 1'b1;
    cycles(4);
    measure(0, 10, 5, 1);
    check("post_rst_pending", 32'(pending), 32'd0);

    for (int k = 0; k < 300; k++) begin
      ld      = ($urandom_range(0, 3) == 0);
      ld_ch   = 4'($urandom_range(0, 3));
      ld_div  = 8'($urandom_range(0, 12));
      ld_high = 8'($urandom_range(0, 14));
      if ($urandom_range(0, 15) == 0) en = 2'($urandom_range(0, 3));
      cycle();
    end
    ld = 1'b0;
    cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
